// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD serial arithmetic blocks.
package bcd_pkg;
  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction; subtraction adds the nines complement.
// Optional BCD_DIGIT_CHECK_EN adds an invalid-digit flag output.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic       invalid
`endif
);

  localparam logic [BCD_W:0] MAX_WIDE = (BCD_W+1)'(BCD_MAX);

  bcd_digit_t     b_adj;
  logic [BCD_W:0] s;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    b_adj = sub ? (bcd_digit_t'(BCD_MAX) - b) : b;
    s     = {1'b0, a} + {1'b0, b_adj} + {{BCD_W{1'b0}}, cin};
    cout  = (s > MAX_WIDE);
    // Adding 6 modulo 16 skips the six unused codes and yields the decimal digit.
    digit = cout ? (s[BCD_W-1:0] + bcd_digit_t'(BCD_CORR)) : s[BCD_W-1:0];
  end

`ifdef BCD_DIGIT_CHECK_EN
  assign invalid = (a > bcd_digit_t'(BCD_MAX)) || (b > bcd_digit_t'(BCD_MAX));
`endif

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first, valid/ready on both sides.
// Optional BCD_DIGIT_CHECK_EN adds a sticky err output flagging any operand digit above 9.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BCD_W*DIGITS-1:0] sum,
`ifdef BCD_DIGIT_CHECK_EN
  output logic                  err,
`endif
  output logic                  cout
);

  localparam int W     = BCD_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_q, b_q;
  logic             sub_q, carry_q;
  bcd_digit_t       a_dig, b_dig, dig_sum;
  logic             dig_cout;
  logic             accept, deliver, last_dig;
`ifdef BCD_DIGIT_CHECK_EN
  logic             dig_invalid;
`endif

  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign last_dig = (state == CALC) && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)   state_next = CALC;
      CALC: if (last_dig) state_next = DONE;
      DONE: if (deliver)  state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_dig = a_q[i*BCD_W +: BCD_W];
        b_dig = b_q[i*BCD_W +: BCD_W];
      end
    end
  end

  bcd_digit_add u_digit (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (dig_sum),
    .cout  (dig_cout)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .invalid (dig_invalid)
`endif
  );

  // Operand and result registers are reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub;
      // Subtraction is A + nines-complement(B) + 1, i.e. the tens complement.
      carry_q <= sub ? 1'b1 : cin;
      cnt     <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else if (state == CALC) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cnt == CNT_W'(i)) sum[i*BCD_W +: BCD_W] <= dig_sum;
      end
      carry_q <= dig_cout;
      cnt     <= cnt + 1'b1;
      if (last_dig) cout <= dig_cout;
`ifdef BCD_DIGIT_CHECK_EN
      err     <= err | dig_invalid;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): decimal reference model feeding a scoreboard queue.
// Define BCD_DIGIT_CHECK_EN for both bench and RTL to exercise the err output.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MOD    = 10000;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BCD_DIGIT_CHECK_EN
  logic         err;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef BCD_DIGIT_CHECK_EN
    .err       (err),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Plain decimal arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input logic cv);
    exp_t e;
    int ai = bcd2int(av);
    int bi = bcd2int(bv);
    int t;
    if (sv) begin
      if (ai >= bi) begin t = ai - bi;       e.cout = 1'b1; end
      else          begin t = MOD + ai - bi; e.cout = 1'b0; end
    end else begin
      t      = ai + bi + int'(cv);
      e.cout = (t >= MOD);
      t      = t % MOD;
    end
    e.sum = int2bcd(t);
    e.err = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic offer(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic cv);
    @(negedge clk);
    a = av; b = bv; sub = sv; cin = cv;
    in_valid = 1'b1;
  endtask

  // Returns #1 after the accept edge with operands scrambled to show they are ignored.
  task automatic accept_wait(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_wait"}, 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic collect(input string tag, output exp_t e);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 50);
    check({tag, "_latency"}, 32'(n), 32'(DIGITS));
    if (sb.size() > 0) e = sb.pop_front();
    else               e = '{sum: 'x, cout: 1'bx, err: 1'bx};
    check({tag, "_sum"},  32'(sum),  32'(e.sum));
    check({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef BCD_DIGIT_CHECK_EN
    check({tag, "_err"},  32'(err),  32'(e.err));
`endif
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cv);
    exp_t e;
    sb.push_back(model(av, bv, sv, cv));
    offer(av, bv, sv, cv);
    accept_wait(tag);
    collect(tag, e);
    handshake(tag);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;

    #22;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    run_op("add",      16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op("wrap1",    16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op("wrap2",    16'h9999, 16'h9999, 1'b0, 1'b1);
    run_op("sub_pos",  16'h5000, 16'h1234, 1'b1, 1'b0);
    run_op("sub_neg",  16'h1234, 16'h5000, 1'b1, 1'b0);
    run_op("sub_eq",   16'h4321, 16'h4321, 1'b1, 1'b1);
    run_op("add_cin",  16'h0500, 16'h0499, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op($sformatf("rand%0d", i), rand_bcd(), rand_bcd(), 1'($urandom), 1'($urandom));

    // Backpressure: result held while a new request waits.
    sb.push_back(model(16'h2222, 16'h3333, 1'b0, 1'b0));
    offer(16'h2222, 16'h3333, 1'b0, 1'b0);
    accept_wait("bp");
    collect("bp", e);
    sb.push_back(model(16'h4321, 16'h1111, 1'b1, 1'b0));
    offer(16'h4321, 16'h1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum",   32'(sum),       32'(e.sum));
      check("bp_hold_cout",  32'(cout),      32'(e.cout));
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    handshake("bp");
    @(posedge clk);
    #1;
    check("bp_accept_next", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    collect("bp2", e);
    handshake("bp2");

    // Reset two digits into an operation: nothing is delivered.
    offer(16'h1234, 16'h1111, 1'b0, 1'b0);
    accept_wait("abort");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum",       32'(sum),       32'd0);
    check("abort_cout",      32'(cout),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    run_op("post_abort", 16'h0042, 16'h0058, 1'b0, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
    // Digit 1 of A is 0xA: 0xA+0 -> 0x0 with carry, so the meaningless result is 0x0100.
    sb.push_back('{sum: 16'h0100, cout: 1'b0, err: 1'b1});
    offer(16'h00A0, 16'h0001, 1'b0, 1'b0);
    accept_wait("bad_digit");
    collect("bad_digit", e);
    handshake("bad_digit");
    run_op("err_clear", 16'h0001, 16'h0001, 1'b0, 1'b0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Parametrised multi-digit packed-BCD adder/subtractor. Processes one BCD digit per clock, least-significant digit first, and reuses a single digit-adder with decimal correction. It is the sequential, N-digit successor of the team's single-digit combinational BCD adder. Sits between operand producers and display/accumulator logic, with valid/ready handshakes on both sides.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); data width = 4*DIGITS

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands (high only in IDLE)
a  in  4*DIGITS  packed BCD operand A; digit i = a[4i+3:4i]
b  in  4*DIGITS  packed BCD operand B
sub  in  1  0 = A+B+cin; 1 = A-B
cin  in  1  decimal carry-in, add mode only
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  4*DIGITS  packed BCD result
cout  out  1  add: decimal carry out; sub: 1 = no borrow (A>=B)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, digit counter=0, sum=0, cout=0, out_valid=0, in_ready=1 after release, internal operand/carry registers=0.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, sub. Latch carry = sub ? 1 : cin. Clear counter. Go to CALC.
- CALC: in_ready=0. Each cycle, digit i=counter:
  - b' = sub ? (9 - b_i) mod 16 : b_i.
  - s = a_i + b' + carry (5-bit, 0..19 for valid digits).
  - If s>9: digit = (s+6)[3:0], carry=1. Else digit=s[3:0], carry=0.
  - Write the digit into sum[4i+3:4i] and increment counter.
  - After digit DIGITS-1 is written, cout=carry and go to DONE.
- Latency: operand accepted at edge k. out_valid is high after edge k+DIGITS. Throughput is one operation per DIGITS+2 cycles minimum.
- DONE: out_valid=1. sum and cout are held stable until out_valid&&out_ready, then go to IDLE and set out_valid=0. sum and cout retain their last values.
- No accept in the same cycle as the output handshake; in_ready rises the cycle after.
- Input changes on a, b, sub, cin outside an accept are ignored.
- Subtraction result is the tens complement when A<B (cout=0).
- Invalid digits (>9) without the feature macro: the arithmetic rules above apply unchanged. No flag is raised; the result is deterministic but meaningless.
- Reset asserted mid-CALC or in DONE: the operation is aborted immediately and all outputs take their reset values. The result is not delivered.
- in_valid while busy: held off by in_ready=0. The producer must hold its request.

Optional Feature:
BCD_DIGIT_CHECK_EN
- Defined: adds output port err (1 bit). err is registered with the result and valid with out_valid. err=1 if any latched digit of a or b is >9. The check is evaluated per digit during CALC and sticky-ORed. It is cleared on accept and reset. sum and cout are computed as normal.
- Undefined: no err port, no check logic.

Decomposition:
- Package bcd_pkg:
  - BCD_W=4
  - BCD_MAX=9
  - BCD_CORR=6
  - bcd_digit_t (4-bit)
  - state enum {IDLE, CALC, DONE}
- One sub-module, bcd_digit_add: combinational single-digit adder. Inputs: digit a, digit b, carry in, sub. Outputs: corrected digit, carry out, invalid flag. Instantiated once in bcd_serial_adder.

Test Plan (DIGITS=4):
- Add: a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, out_valid exactly 4 cycles after accept edge.
- Wrap: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
- Subtract: a=0x5000, b=0x1234, sub=1 -> sum=0x3766, cout=1. Also a=0x1234, b=0x5000 -> sum=0x6234, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid, sum, cout stable, in_ready=0. in_valid with new operands is not accepted until the cycle after the out handshake.
- Reset mid-CALC: drop rst_n after 2 digits -> immediate out_valid=0, sum=0, cout=0. After release, in_ready=1 and the next operation is correct.
- With BCD_DIGIT_CHECK_EN: a=0x00A0, b=0x0001 -> err=1 with out_valid. The next operation 0x0001+0x0001 -> sum=0x0002, err=0.
